// File: rtl/tone_period_detector_if.sv
// Square-wave input and published tone outputs of the period detector.
// master = detector side, slave = source/consumer side.
interface tone_period_detector_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic                    square_wave_in;
  logic [PERIOD_WIDTH-1:0] tone;
  logic                    tone_valid;
  logic                    locked;

  modport master (input square_wave_in, output tone, tone_valid, locked);
  modport slave  (output square_wave_in, input tone, tone_valid, locked);
endinterface

// File: rtl/tone_period_detector.sv
// Measures the half-period of an asynchronous square wave and publishes it
// as a tone word once the same interval repeats STABLE_COUNT times.
module tone_period_detector #(
  parameter int          PERIOD_WIDTH = 24,
  parameter int          SYNC_STAGES  = 2,
  parameter int          STABLE_COUNT = 2,
  parameter int unsigned TIMEOUT      = (1 << 24) - 1
) (
  input logic                    clk,
  input logic                    rst,
  tone_period_detector_if.master bus
);
  localparam int MW = $clog2(STABLE_COUNT + 1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] TO      = PERIOD_WIDTH'(TIMEOUT);
  localparam logic [MW-1:0]           SC      = MW'(STABLE_COUNT);

  typedef enum logic [1:0] {SILENT, ARMED, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_pipe;
  logic                    prev_q;
  logic                    edge_det;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] cand_q, cand_d;
  logic [PERIOD_WIDTH-1:0] tone_q, tone_d;
  logic [MW-1:0]           mcnt_q, mcnt_d, mcnt_upd;
  logic                    tv_q, tv_d;
  logic                    lock_q, lock_d;

  assign edge_det = sync_pipe[SYNC_STAGES-1] != prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    tone_d  = tone_q;
    mcnt_d  = mcnt_q;
    tv_d    = 1'b0;
    lock_d  = lock_q;
    // match count as it will be after this edge's sample (cnt_q) is folded in
    if (cnt_q == cand_q)
      mcnt_upd = (mcnt_q == SC) ? SC : mcnt_q + 1'b1;
    else
      mcnt_upd = MW'(1);

    case (state_q)
      SILENT: begin
        if (edge_det) begin
          cnt_d   = PERIOD_WIDTH'(1);
          state_d = ARMED;
        end
      end
      ARMED, LOCKED: begin
        if (edge_det) begin
          cnt_d  = PERIOD_WIDTH'(1);
          cand_d = cnt_q;
          mcnt_d = mcnt_upd;
          if (mcnt_upd == SC && cnt_q != tone_q) begin
            tone_d  = cnt_q;
            tv_d    = 1'b1;
            lock_d  = 1'b1;
            state_d = LOCKED;
          end
        end else if (cnt_q == TO) begin
          // an edge on this same cycle would have taken the branch above
          state_d = SILENT;
          cand_d  = '0;
          mcnt_d  = '0;
          lock_d  = 1'b0;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (tone_q != '0) begin
            tone_d = '0;
            tv_d   = 1'b1;
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = SILENT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SILENT;
      sync_pipe <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      cand_q    <= '0;
      tone_q    <= '0;
      mcnt_q    <= '0;
      tv_q      <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.square_wave_in};
      prev_q    <= sync_pipe[SYNC_STAGES-1];
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      tone_q    <= tone_d;
      mcnt_q    <= mcnt_d;
      tv_q      <= tv_d;
      lock_q    <= lock_d;
    end
  end

  assign bus.tone       = tone_q;
  assign bus.tone_valid = tv_q;
  assign bus.locked     = lock_q;
endmodule
